// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, defaults and width helpers for the 3x3 convolution sequencer
package conv_pkg;

  localparam int DEF_IMG_DIM = 8;
  localparam int DEF_K_DIM   = 3;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ACC_W   = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_K,
    S_LOAD_I,
    S_MAC,
    S_OUT,
    S_DONE
  } conv_state_t;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Side length of a valid (no padding, stride 1) convolution.
  function automatic int out_dim(input int img_dim, input int k_dim);
    return img_dim - k_dim + 1;
  endfunction

  // Smallest accumulator that holds a full window sum without wrapping.
  function automatic int min_acc_w(input int data_w, input int k_dim);
    return 2 * data_w + $clog2(k_dim * k_dim);
  endfunction

  localparam int OUT_DIM = out_dim(DEF_IMG_DIM, DEF_K_DIM);
  localparam int POS_W   = cnt_w(OUT_DIM);
  localparam int WIN_W   = cnt_w(DEF_K_DIM);

endpackage

// File: rtl/conv_sequencer_if.sv
// rtl/conv_sequencer_if.sv - input beat stream and tagged result stream of the convolution sequencer
interface conv_sequencer_if
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int POS_W  = conv_pkg::POS_W
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic [POS_W-1:0]         out_row;
  logic [POS_W-1:0]         out_col;

  // Producer of weights/pixels and consumer of results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col
  );

  // The sequencer itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col
  );
endinterface

// File: rtl/conv_mac.sv
// rtl/conv_mac.sv - signed multiply, sign-extend and accumulate with clear/enable
module conv_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_x;

  assign prod   = a * b;
  assign prod_x = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // Clear restarts the sum; when combined with enable the first product is loaded directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= en ? prod_x : '0;
    end else if (en) begin
      acc <= acc + prod_x;
    end
  end
endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - 3x3 convolution sequencer; CONV_RELU_EN enables ReLU on results
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_DIM = DEF_IMG_DIM,
  parameter int K_DIM   = DEF_K_DIM,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  conv_sequencer_if.slave bus
);
  localparam int K_N   = K_DIM * K_DIM;
  localparam int I_N   = IMG_DIM * IMG_DIM;
  localparam int O_DIM = out_dim(IMG_DIM, K_DIM);
  localparam int LD_W  = cnt_w(I_N);
  localparam int KI_W  = cnt_w(K_N);
  localparam int WN_W  = cnt_w(K_DIM);
  localparam int PS_W  = cnt_w(O_DIM);

  conv_state_t state, state_nxt;

  logic signed [DATA_W-1:0] kbuf [K_N];
  logic signed [DATA_W-1:0] ibuf [I_N];

  logic [LD_W-1:0] ld_cnt;
  logic [WN_W-1:0] win_r, win_c;
  logic [PS_W-1:0] pos_i, pos_j;

  logic                     beat;
  logic                     ld_last_k, ld_last_i;
  logic                     win_last, pos_last;
  logic [KI_W-1:0]          k_idx;
  logic [LD_W-1:0]          p_idx;
  logic signed [DATA_W-1:0] w_sel, p_sel;
  logic                     mac_clear, mac_en;
  logic signed [ACC_W-1:0]  acc;

  assign bus.in_ready  = (state == S_LOAD_K) || (state == S_LOAD_I);
  assign bus.out_valid = (state == S_OUT);
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign bus.out_row   = pos_i;
  assign bus.out_col   = pos_j;

  assign beat      = bus.in_valid && bus.in_ready;
  assign ld_last_k = (ld_cnt == LD_W'(K_N - 1));
  assign ld_last_i = (ld_cnt == LD_W'(I_N - 1));
  assign win_last  = (win_r == WN_W'(K_DIM - 1)) && (win_c == WN_W'(K_DIM - 1));
  assign pos_last  = (pos_i == PS_W'(O_DIM - 1)) && (pos_j == PS_W'(O_DIM - 1));

  // Window tap addressing: weight (r,c) pairs with pixel (i+r, j+c).
  assign k_idx = KI_W'(int'(win_r) * K_DIM + int'(win_c));
  assign p_idx = LD_W'((int'(pos_i) + int'(win_r)) * IMG_DIM + int'(pos_j) + int'(win_c));
  assign w_sel = kbuf[k_idx];
  assign p_sel = ibuf[p_idx];

  assign mac_en    = (state == S_MAC);
  assign mac_clear = mac_en && (win_r == '0) && (win_c == '0);

  // The accumulator is frozen outside MAC, so it already holds the result throughout OUT.
`ifdef CONV_RELU_EN
  assign bus.out_data = acc[ACC_W-1] ? '0 : acc;
`else
  assign bus.out_data = acc;
`endif

  conv_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (mac_clear),
    .en    (mac_en),
    .a     (w_sel),
    .b     (p_sel),
    .acc   (acc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; abort overrides every transition including an output handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD_K;
      S_LOAD_K: if (beat && ld_last_k) state_nxt = S_LOAD_I;
      S_LOAD_I: if (beat && ld_last_i) state_nxt = S_MAC;
      S_MAC:    if (win_last) state_nxt = S_OUT;
      S_OUT:    if (bus.out_ready) state_nxt = pos_last ? S_DONE : S_MAC;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Load, window and position counters; every job starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt <= '0;
      win_r  <= '0;
      win_c  <= '0;
      pos_i  <= '0;
      pos_j  <= '0;
    end else if (abort || state == S_IDLE) begin
      ld_cnt <= '0;
      win_r  <= '0;
      win_c  <= '0;
      pos_i  <= '0;
      pos_j  <= '0;
    end else begin
      case (state)
        S_LOAD_K: if (beat) ld_cnt <= ld_last_k ? '0 : ld_cnt + 1'b1;
        S_LOAD_I: if (beat) ld_cnt <= ld_last_i ? '0 : ld_cnt + 1'b1;
        S_MAC: begin
          if (win_c == WN_W'(K_DIM - 1)) begin
            win_c <= '0;
            win_r <= (win_r == WN_W'(K_DIM - 1)) ? '0 : win_r + 1'b1;
          end else begin
            win_c <= win_c + 1'b1;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            if (pos_j == PS_W'(O_DIM - 1)) begin
              pos_j <= '0;
              pos_i <= (pos_i == PS_W'(O_DIM - 1)) ? '0 : pos_i + 1'b1;
            end else begin
              pos_j <= pos_j + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Weight and pixel buffers; contents are only meaningful after a full load.
  always_ff @(posedge clk) begin
    if (beat && state == S_LOAD_K) kbuf[KI_W'(ld_cnt)] <= bus.in_data;
    if (beat && state == S_LOAD_I) ibuf[ld_cnt] <= bus.in_data;
  end
endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - randomized self-checking bench for conv_sequencer
module tb_conv_sequencer;
  import conv_pkg::*;

  localparam int IMG = DEF_IMG_DIM;
  localparam int K   = DEF_K_DIM;
  localparam int DW  = DEF_DATA_W;
  localparam int AW  = DEF_ACC_W;
  localparam int OD  = IMG - K + 1;
  localparam int NOUT = OD * OD;
  localparam int FIRST_OUT = 1 + K*K + IMG*IMG + K*K;
  localparam int DONE_AT   = 1 + K*K + IMG*IMG + NOUT*(K*K+1) + 1 - 1;

  logic clk;
  logic rst, start, abort, busy, done;

  conv_sequencer_if #(.DATA_W(DW), .ACC_W(AW), .POS_W(POS_W)) bus ();

  conv_sequencer #(.IMG_DIM(IMG), .K_DIM(K), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [DW-1:0] kern [K*K];
  logic signed [DW-1:0] img  [IMG*IMG];

  int exp_d[$];
  int got_d[$], got_r[$], got_c[$], hs_cyc[$];
  int cyc, first_ov, done_cyc, n_done, busy_after_done, stab_err;
  int ab_cyc, ab_busy, ab_iready, ab_ovalid;
  int rs_busy, rs_done, rs_iready, rs_ovalid, rs_data, rs_row, rs_col;

  // Direct convolution over the stored kernel and image.
  task automatic build_expected();
    int s;
    exp_d.delete();
    for (int i = 0; i < OD; i++)
      for (int j = 0; j < OD; j++) begin
        s = 0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            s += int'(img[(i+r)*IMG + j + c]) * int'(kern[r*K + c]);
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        exp_d.push_back(s);
      end
  endtask

  task automatic set_image_ramp();
    for (int k = 0; k < IMG*IMG; k++) img[k] = DW'(k);
  endtask

  task automatic run_job(input int in_mode, input int out_mode, input bit extra_start,
                         input int abort_beat, input int rst_cyc, input int hold_n);
    int kb, ib, hold, pd, pr, pc;
    bit fin, pend, seen_done;
    kb = 0; ib = 0; hold = 0; pd = 0; pr = 0; pc = 0;
    fin = 0; pend = 0; seen_done = 0;
    got_d.delete(); got_r.delete(); got_c.delete(); hs_cyc.delete();
    first_ov = -1; done_cyc = -1; n_done = 0; busy_after_done = -1; stab_err = 0;
    ab_cyc = -1; ab_busy = -1; ab_iready = -1; ab_ovalid = -1;
    @(posedge clk); #1;
    start = 1'b1;
    cyc = 0;
    while (!fin) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      if (seen_done) begin
        busy_after_done = busy;
        fin = 1;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
        seen_done = 1;
      end
      if (ab_cyc >= 0 && cyc == ab_cyc + 1) begin
        ab_busy = busy; ab_iready = bus.in_ready; ab_ovalid = bus.out_valid;
      end
      if (ab_cyc >= 0 && cyc >= ab_cyc + 8) fin = 1;
      if (bus.out_valid) begin
        if (first_ov < 0) first_ov = cyc;
        if (pend && (int'(bus.out_data) != pd || int'(bus.out_row) != pr || int'(bus.out_col) != pc))
          stab_err++;
      end else if (pend) begin
        stab_err++;
      end
      bus.in_valid = (in_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      bus.in_data  = DW'($urandom);
      if (bus.in_valid && bus.in_ready) begin
        if (kb < K*K) begin
          bus.in_data = kern[kb];
          kb++;
        end else if (ib < IMG*IMG) begin
          if (abort_beat >= 0 && ib == abort_beat && ab_cyc < 0) begin
            abort = 1'b1;
            ab_cyc = cyc;
          end
          bus.in_data = img[ib];
          ib++;
        end
      end
      bus.out_ready = (out_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (bus.out_valid && got_d.size() == 0 && hold < hold_n) begin
        bus.out_ready = 1'b0;
        hold++;
      end
      if (bus.out_valid && bus.out_ready) begin
        got_d.push_back(int'(bus.out_data));
        got_r.push_back(int'(bus.out_row));
        got_c.push_back(int'(bus.out_col));
        hs_cyc.push_back(cyc);
        pend = 0;
      end else if (bus.out_valid) begin
        pend = 1;
        pd = int'(bus.out_data); pr = int'(bus.out_row); pc = int'(bus.out_col);
      end else begin
        pend = 0;
      end
      if (extra_start && (cyc == 40 || cyc == 150)) start = 1'b1;
      if (rst_cyc > 0 && cyc == rst_cyc) begin
        rst = 1'b1;
        #1;
        rs_busy = busy; rs_done = done; rs_iready = bus.in_ready; rs_ovalid = bus.out_valid;
        rs_data = int'(bus.out_data); rs_row = int'(bus.out_row); rs_col = int'(bus.out_col);
        #1;
        rst = 1'b0;
        fin = 1;
      end
      if (!fin && cyc >= 5000) begin
        n_cmp++; n_bad++;
        $display("FAIL job_timeout cycles=%0d outputs=%0d required done within budget", cyc, got_d.size());
        fin = 1;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, bus.in_ready, bus.out_valid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctrl got busy/done/in_ready/out_valid=%b required 0000",
               {busy, done, bus.in_ready, bus.out_valid});
    end
    n_cmp++;
    if (bus.out_data !== '0 || bus.out_row !== '0 || bus.out_col !== '0) begin
      n_bad++;
      $display("FAIL reset_out got data=%0d row=%0d col=%0d required 0/0/0",
               bus.out_data, bus.out_row, bus.out_col);
    end
  endtask

  task automatic test_ones();
    for (int k = 0; k < K*K; k++) kern[k] = 1;
    set_image_ramp();
    build_expected();
    run_job(0, 0, 0, -1, 0, 0);
    n_cmp++;
    if (first_ov !== FIRST_OUT) begin
      n_bad++; $display("FAIL ones_first_valid got cycle %0d required %0d", first_ov, FIRST_OUT);
    end
    n_cmp++;
    if (done_cyc !== DONE_AT || n_done !== 1) begin
      n_bad++; $display("FAIL ones_done got cycle %0d count %0d required cycle %0d count 1", done_cyc, n_done, DONE_AT);
    end
    n_cmp++;
    if (busy_after_done !== 0) begin
      n_bad++; $display("FAIL ones_busy_fall got %0d required 0", busy_after_done);
    end
    n_cmp++;
    if (got_d.size() != NOUT) begin
      n_bad++; $display("FAIL ones_count got %0d required %0d", got_d.size(), NOUT);
    end else begin
      n_cmp++;
      if (got_d[0] != 81 || got_d[NOUT-1] != 486) begin
        n_bad++; $display("FAIL ones_corners got %0d,%0d required 81,486", got_d[0], got_d[NOUT-1]);
      end
    end
    for (int k = 0; k < got_d.size() && k < NOUT; k++) begin
      n_cmp++;
      if (got_d[k] != exp_d[k] || got_r[k] != k/OD || got_c[k] != k%OD) begin
        n_bad++;
        $display("FAIL ones_out[%0d] got (%0d,%0d)=%0d required (%0d,%0d)=%0d",
                 k, got_r[k], got_c[k], got_d[k], k/OD, k%OD, exp_d[k]);
      end
    end
  endtask

  task automatic test_centre();
    for (int k = 0; k < K*K; k++) kern[k] = 0;
    kern[(K*K)/2] = 1;
    set_image_ramp();
    build_expected();
    run_job(0, 0, 0, -1, 0, 0);
    n_cmp++;
    if (got_d.size() != NOUT) begin
      n_bad++; $display("FAIL centre_count got %0d required %0d", got_d.size(), NOUT);
    end else begin
      n_cmp++;
      if (got_d[0] != 9 || got_d[NOUT-1] != 54) begin
        n_bad++; $display("FAIL centre_corners got %0d,%0d required 9,54", got_d[0], got_d[NOUT-1]);
      end
    end
    for (int k = 0; k < got_d.size() && k < NOUT; k++) begin
      n_cmp++;
      if (got_d[k] != exp_d[k] || got_r[k] != k/OD || got_c[k] != k%OD) begin
        n_bad++;
        $display("FAIL centre_out[%0d] got (%0d,%0d)=%0d required (%0d,%0d)=%0d",
                 k, got_r[k], got_c[k], got_d[k], k/OD, k%OD, exp_d[k]);
      end
    end
  endtask

  task automatic test_negative();
    int want;
`ifdef CONV_RELU_EN
    want = 0;
`else
    want = -81;
`endif
    for (int k = 0; k < K*K; k++) kern[k] = -1;
    set_image_ramp();
    build_expected();
    run_job(0, 0, 0, -1, 0, 0);
    n_cmp++;
    if (got_d.size() == 0 || got_d[0] != want) begin
      n_bad++; $display("FAIL neg_first got %0d required %0d", (got_d.size() > 0) ? got_d[0] : 12345, want);
    end
    n_cmp++;
    if (first_ov !== FIRST_OUT || done_cyc !== DONE_AT) begin
      n_bad++; $display("FAIL neg_timing got first=%0d done=%0d required %0d/%0d", first_ov, done_cyc, FIRST_OUT, DONE_AT);
    end
    for (int k = 0; k < got_d.size() && k < NOUT; k++) begin
      n_cmp++;
      if (got_d[k] != exp_d[k]) begin
        n_bad++; $display("FAIL neg_out[%0d] got %0d required %0d", k, got_d[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < K*K; k++) kern[k] = DW'($urandom);
    for (int k = 0; k < IMG*IMG; k++) img[k] = DW'($urandom);
    build_expected();
    run_job(0, 0, 0, -1, 0, 20);
    n_cmp++;
    if (stab_err != 0) begin
      n_bad++; $display("FAIL bp_stable got %0d unstable cycles required 0", stab_err);
    end
    n_cmp++;
    if (hs_cyc.size() < 2 || hs_cyc[0] != FIRST_OUT + 20 || hs_cyc[1] - hs_cyc[0] != K*K + 1) begin
      n_bad++;
      $display("FAIL bp_timing got hs0=%0d gap=%0d required hs0=%0d gap=%0d",
               (hs_cyc.size() > 0) ? hs_cyc[0] : -1, (hs_cyc.size() > 1) ? hs_cyc[1] - hs_cyc[0] : -1,
               FIRST_OUT + 20, K*K + 1);
    end
    n_cmp++;
    if (got_d.size() != NOUT || done_cyc != DONE_AT + 20) begin
      n_bad++; $display("FAIL bp_done got outputs=%0d done=%0d required %0d/%0d", got_d.size(), done_cyc, NOUT, DONE_AT + 20);
    end
    for (int k = 0; k < got_d.size() && k < NOUT; k++) begin
      n_cmp++;
      if (got_d[k] != exp_d[k] || got_r[k] != k/OD || got_c[k] != k%OD) begin
        n_bad++;
        $display("FAIL bp_out[%0d] got (%0d,%0d)=%0d required (%0d,%0d)=%0d",
                 k, got_r[k], got_c[k], got_d[k], k/OD, k%OD, exp_d[k]);
      end
    end
  endtask

  task automatic test_stalls();
    for (int k = 0; k < K*K; k++) kern[k] = DW'($urandom);
    for (int k = 0; k < IMG*IMG; k++) img[k] = DW'($urandom);
    build_expected();
    run_job(1, 1, 1, -1, 0, 0);
    n_cmp++;
    if (n_done != 1 || got_d.size() != NOUT) begin
      n_bad++; $display("FAIL stall_job got done=%0d outputs=%0d required 1/%0d", n_done, got_d.size(), NOUT);
    end
    n_cmp++;
    if (stab_err != 0) begin
      n_bad++; $display("FAIL stall_stable got %0d unstable cycles required 0", stab_err);
    end
    for (int k = 0; k < got_d.size() && k < NOUT; k++) begin
      n_cmp++;
      if (got_d[k] != exp_d[k] || got_r[k] != k/OD || got_c[k] != k%OD) begin
        n_bad++;
        $display("FAIL stall_out[%0d] got (%0d,%0d)=%0d required (%0d,%0d)=%0d",
                 k, got_r[k], got_c[k], got_d[k], k/OD, k%OD, exp_d[k]);
      end
    end
  endtask

  task automatic test_abort();
    for (int k = 0; k < K*K; k++) kern[k] = DW'($urandom);
    for (int k = 0; k < IMG*IMG; k++) img[k] = DW'($urandom);
    run_job(0, 0, 0, 30, 0, 0);
    n_cmp++;
    if (ab_cyc < 0 || ab_busy !== 0 || ab_iready !== 0 || ab_ovalid !== 0) begin
      n_bad++;
      $display("FAIL abort_idle got at=%0d busy=%0d in_ready=%0d out_valid=%0d required idle",
               ab_cyc, ab_busy, ab_iready, ab_ovalid);
    end
    n_cmp++;
    if (n_done != 0 || got_d.size() != 0) begin
      n_bad++; $display("FAIL abort_done got done=%0d outputs=%0d required 0/0", n_done, got_d.size());
    end
    build_expected();
    run_job(0, 0, 0, -1, 0, 0);
    n_cmp++;
    if (got_d.size() != NOUT || done_cyc != DONE_AT) begin
      n_bad++; $display("FAIL abort_rerun got outputs=%0d done=%0d required %0d/%0d", got_d.size(), done_cyc, NOUT, DONE_AT);
    end
    for (int k = 0; k < got_d.size() && k < NOUT; k++) begin
      n_cmp++;
      if (got_d[k] != exp_d[k]) begin
        n_bad++; $display("FAIL abort_rerun_out[%0d] got %0d required %0d", k, got_d[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_rst_mid_mac();
    for (int k = 0; k < K*K; k++) kern[k] = DW'($urandom);
    for (int k = 0; k < IMG*IMG; k++) img[k] = DW'($urandom);
    run_job(0, 0, 0, -1, FIRST_OUT + 15, 0);
    n_cmp++;
    if (rs_busy !== 0 || rs_done !== 0 || rs_iready !== 0 || rs_ovalid !== 0) begin
      n_bad++;
      $display("FAIL rst_ctrl got busy=%0d done=%0d in_ready=%0d out_valid=%0d required 0",
               rs_busy, rs_done, rs_iready, rs_ovalid);
    end
    n_cmp++;
    if (rs_data != 0 || rs_row != 0 || rs_col != 0 || n_done != 0) begin
      n_bad++;
      $display("FAIL rst_out got data=%0d row=%0d col=%0d done=%0d required 0", rs_data, rs_row, rs_col, n_done);
    end
    for (int k = 0; k < K*K; k++) kern[k] = DW'($urandom);
    build_expected();
    run_job(1, 0, 0, -1, 0, 0);
    n_cmp++;
    if (got_d.size() != NOUT || n_done != 1) begin
      n_bad++; $display("FAIL rst_rerun got outputs=%0d done=%0d required %0d/1", got_d.size(), n_done, NOUT);
    end
    for (int k = 0; k < got_d.size() && k < NOUT; k++) begin
      n_cmp++;
      if (got_d[k] != exp_d[k]) begin
        n_bad++; $display("FAIL rst_rerun_out[%0d] got %0d required %0d", k, got_d[k], exp_d[k]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_ones();
    test_centre();
    test_negative();
    test_backpressure();
    test_stalls();
    test_abort();
    test_rst_mid_mac();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
